uart_tx_ctrl: RTL

Memory-mapped transmit controller that sequences the shared `uart_tx` serializer from the RISC-V core's data bus. It buffers bytes written by software in a FIFO and runs the `tx_start`/`tx_done` handshake, one frame at a time. It latches the stop-bit configuration per frame, detects a stalled transmitter with a watchdog, and raises an interrupt. It sits between the data-memory bus decoder and `uart_tx`.

---
 rtl/uart_tx_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped transmit controller: byte FIFO feeding the uart_tx start/done
// handshake, with per-frame stop-bit latch, stall watchdog and level interrupt.
module uart_tx_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx_start,
   output logic [7:0]  d_tx,
   output logic        two_stop_bit,
   input  logic        tx_done,
   output logic        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic            en_q, en_d, stop2_q, stop2_d, irq_en_q, irq_en_d;
   logic            ovf_q, ovf_d, tmo_q, tmo_d, irq_q, irq_d;
   logic            tx_start_q, tx_start_d, two_q, two_d;
   logic [7:0]      d_tx_q, d_tx_d;

   logic            wr_data, wr_ctrl, wr_clr, empty, full, push, pop, wd_hit, tmo_evt;
   logic [3:0]      cnt4;
   logic            unused_ok;

   assign unused_ok = ^{addr[1:0], wdata[31:8]};

   assign wr_data = sel & we & (addr[3:2] == 2'd0);
   assign wr_ctrl = sel & we & (addr[3:2] == 2'd1);
   assign wr_clr  = sel & we & (addr[3:2] == 2'd3);
   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(FIFO_DEPTH));
   // A pop frees no slot for a same-cycle push: full is judged on the old count.
   assign push    = wr_data & ~full;
   assign pop     = (state_q == IDLE) & en_q & ~empty;
   assign wd_hit  = (wd_q == WW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic, including watchdog abort
   always_comb begin
      state_d = state_q;
      tmo_evt = 1'b0;
      case (state_q)
         IDLE:    if (pop) state_d = SEND;
         SEND: begin
            if (tx_done) state_d = RELEASE;
            else if (wd_hit) begin
               state_d = IDLE;
               tmo_evt = 1'b1;
            end
         end
         RELEASE: begin
            if (!tx_done) state_d = IDLE;
            else if (wd_hit) begin
               state_d = IDLE;
               tmo_evt = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: registered handshake outputs follow the next state
   always_comb begin
      tx_start_d = (state_d == SEND);
      d_tx_d     = pop ? mem_q[rptr_q] : d_tx_q;
      two_d      = pop ? stop2_q : two_q;
   end

   // Datapath next-state: FIFO, control/status flags, watchdog, interrupt
   always_comb begin
      wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d   = pop  ? rptr_q + 1'b1 : rptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      en_d     = wr_ctrl ? wdata[0] : en_q;
      stop2_d  = wr_ctrl ? wdata[1] : stop2_q;
      irq_en_d = wr_ctrl ? wdata[2] : irq_en_q;
      ovf_d    = (ovf_q & ~(wr_clr & wdata[3])) | (wr_data & full);
      tmo_d    = (tmo_q & ~(wr_clr & wdata[4])) | tmo_evt;
      wd_d     = ((state_d != state_q) || (state_q == IDLE)) ? '0 : wd_q + 1'b1;
      irq_d    = irq_en_q & ((empty & (state_q == IDLE)) | ovf_q | tmo_q);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         wd_q       <= '0;
         en_q       <= 1'b0;
         stop2_q    <= 1'b0;
         irq_en_q   <= 1'b0;
         ovf_q      <= 1'b0;
         tmo_q      <= 1'b0;
         irq_q      <= 1'b0;
         tx_start_q <= 1'b0;
         two_q      <= 1'b0;
         d_tx_q     <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         wd_q       <= wd_d;
         en_q       <= en_d;
         stop2_q    <= stop2_d;
         irq_en_q   <= irq_en_d;
         ovf_q      <= ovf_d;
         tmo_q      <= tmo_d;
         irq_q      <= irq_d;
         tx_start_q <= tx_start_d;
         two_q      <= two_d;
         d_tx_q     <= d_tx_d;
      end
   end

   assign cnt4 = 4'(count_q);

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (addr[3:2])
            2'd1: rdata[2:0] = {irq_en_q, stop2_q, en_q};
            2'd2: begin
               rdata[4:0]  = {tmo_q, ovf_q, (state_q != IDLE), full, empty};
               rdata[11:8] = cnt4;
            end
            default: rdata = '0;
         endcase
      end
   end

   assign tx_start     = tx_start_q;
   assign d_tx         = d_tx_q;
   assign two_stop_bit = two_q;
   assign irq          = irq_q;

endmodule
